// File: rtl/dac_frame_scheduler.sv
// rtl/dac_frame_scheduler.sv - round-robin sequencer for a shared serial dual 12-bit DAC
//
// Two sample producers request conversions over req/ack. A granted request
// becomes one 16-bit command frame shifted out MSB first on sck/sdi under cs_n.
// A sample tick pulses ldac_n once the link is idle, so every channel written
// since the previous tick updates together.
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   tick                 one-cycle sample-rate strobe
//   req_a/data_a/ack_a   channel A request, 12-bit code, one-cycle grant
//   req_b/data_b/ack_b   channel B request, 12-bit code, one-cycle grant
//   sck, sdi, cs_n       DAC serial link (registered)
//   ldac_n               DAC latch strobe (registered)
//   busy                 high whenever the sequencer is not idle

module dac_frame_scheduler #(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        req_a,
  input  logic [11:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [11:0] data_b,
  output logic        ack_b,
  output logic        sck,
  output logic        sdi,
  output logic        cs_n,
  output logic        ldac_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_LATCH
  } state_t;

  localparam logic [4:0] HALF_LAST  = 5'(DIV - 1);
  localparam logic [4:0] LATCH_LAST = 5'(2 * DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] sreg;
  logic        gnt_b;
  logic        ptr_b;
  logic        tick_pend;
  logic [1:0]  written;

  logic half_done;
  logic pend_eff;
  logic pick_b;
  logic last_fall;
  logic latch_end;

  assign half_done = (cnt == HALF_LAST);
  // A tick arriving in the same IDLE cycle as a request must still win.
  assign pend_eff  = tick_pend | tick;
  // Lone requester wins outright; on contention the pointer decides.
  assign pick_b    = req_b & (~req_a | ptr_b);
  // 16th falling sck edge: the final high phase has just completed.
  assign last_fall = (state == S_SHIFT) && half_done && sck && (bit_cnt == 4'd15);
  assign latch_end = (state == S_LATCH) && (cnt == LATCH_LAST);

  // The MSB of the shift register is the pin; it drains to zero after a frame.
  assign sdi = sreg[15];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pend_eff) begin
          // Nothing written since the last latch: drop the tick silently.
          if (written != 2'b00) state_nxt = S_LATCH;
        end else if (req_a || req_b) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (last_fall) state_nxt = S_GAP;
      S_GAP:   if (half_done) state_nxt = S_IDLE;
      S_LATCH: if (latch_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack_a = (state == S_LOAD) && !gnt_b;
    ack_b = (state == S_LOAD) && gnt_b;
    busy  = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      sreg      <= '0;
      sck       <= 1'b0;
      cs_n      <= 1'b1;
      ldac_n    <= 1'b1;
      gnt_b     <= 1'b0;
      ptr_b     <= 1'b0;
      tick_pend <= 1'b0;
      written   <= 2'b00;
    end else begin
      // Pin strobes follow the state being entered so they are flop outputs.
      cs_n   <= (state_nxt != S_SHIFT);
      ldac_n <= (state_nxt != S_LATCH);

      // One counter times every phase; it restarts on each state change and
      // on each sck half-period while shifting.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == S_SHIFT && half_done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 5'd1;
      end

      if (state == S_SHIFT && half_done) begin
        sck <= ~sck;
      end else if (state != S_SHIFT) begin
        sck <= 1'b0;
      end

      if (state == S_SHIFT && half_done && sck) begin
        bit_cnt <= bit_cnt + 4'd1;
      end else if (state != S_SHIFT) begin
        bit_cnt <= '0;
      end

      if (state == S_LOAD) begin
        sreg <= {gnt_b, 3'b011, (gnt_b ? data_b : data_a)};
      end else if (state == S_SHIFT && half_done && sck) begin
        sreg <= {sreg[14:0], 1'b0};
      end

      if (state == S_IDLE && state_nxt == S_LOAD) begin
        gnt_b <= pick_b;
      end
      if (state == S_LOAD) begin
        ptr_b <= ~gnt_b;
      end

      if (state == S_LOAD) begin
        written[gnt_b] <= 1'b1;
      end else if (latch_end) begin
        written <= 2'b00;
      end

      // A tick on the edge that ends LATCH survives as the next pending tick.
      if (latch_end) begin
        tick_pend <= tick;
      end else if (state == S_IDLE && pend_eff && written == 2'b00) begin
        tick_pend <= 1'b0;
      end else if (tick) begin
        tick_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb/tb_dac_frame_scheduler.sv - self-checking bench for dac_frame_scheduler

module tb_dac_frame_scheduler;

  localparam int DIV = 2;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        req_a;
  logic [11:0] data_a;
  logic        ack_a;
  logic        req_b;
  logic [11:0] data_b;
  logic        ack_b;
  logic        sck;
  logic        sdi;
  logic        cs_n;
  logic        ldac_n;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dac_frame_scheduler #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .req_a  (req_a),
    .data_a (data_a),
    .ack_a  (ack_a),
    .req_b  (req_b),
    .data_b (data_b),
    .ack_b  (ack_b),
    .sck    (sck),
    .sdi    (sdi),
    .cs_n   (cs_n),
    .ldac_n (ldac_n),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: activity kind plus elapsed cycles in that activity.
  // 0 = idle, 1 = frame (t=0 grant, 1..32*DIV serial, then DIV of gap), 2 = latch.
  int          m_act = 0;
  int          m_t = 0;
  bit          m_ch = 0;
  bit          m_ptr = 0;
  bit          m_pend = 0;
  bit  [1:0]   m_written = 0;
  logic [15:0] m_word = 0;
  bit          model_on = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_ptr = 0; m_pend = 0; m_written = 0; model_on = 1;
    end else begin
      case (m_act)
        0: begin
          if (m_pend || tick) begin
            if (m_written != 0) begin m_act = 2; m_t = 0; m_pend = 1; end
            else m_pend = 0;
          end else if (req_a || req_b) begin
            m_ch  = (req_a && req_b) ? m_ptr : req_b;
            m_act = 1; m_t = 0;
          end
        end
        1: begin
          if (m_t == 0) begin
            m_word = {m_ch, 1'b0, 1'b1, 1'b1, (m_ch ? data_b : data_a)};
            m_written[m_ch] = 1'b1;
            m_ptr = !m_ch;
          end
          if (tick) m_pend = 1;
          if (m_t == 33 * DIV) m_act = 0; else m_t++;
        end
        default: begin
          if (m_t == 2 * DIV - 1) begin m_act = 0; m_written = 0; m_pend = tick; end
          else begin m_t++; if (tick) m_pend = 1; end
        end
      endcase
    end
  end

  // {ack_a, ack_b, sck, sdi, cs_n, ldac_n, busy}
  function automatic logic [6:0] outs();
    return {ack_a, ack_b, sck, sdi, cs_n, ldac_n, busy};
  endfunction

  function automatic logic [6:0] model_outs();
    logic e_aa, e_ab, e_sck, e_sdi, e_cs, e_ld, e_busy;
    int u;
    e_aa = 0; e_ab = 0; e_sck = 0; e_sdi = 0; e_cs = 1; e_ld = 1; e_busy = 0;
    if (m_act == 1) begin
      e_busy = 1;
      if (m_t == 0) begin
        e_aa = !m_ch; e_ab = m_ch;
      end else if (m_t <= 32 * DIV) begin
        u     = m_t - 1;
        e_cs  = 0;
        e_sck = ((u / DIV) % 2) == 1;
        e_sdi = m_word[15 - u / (2 * DIV)];
      end
    end else if (m_act == 2) begin
      e_busy = 1; e_ld = 0;
    end
    return {e_aa, e_ab, e_sck, e_sdi, e_cs, e_ld, e_busy};
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if (outs() !== model_outs()) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got=%b exp=%b", $time, outs(), model_outs());
      end
    end
  end

  // Word capture as the DAC sees it: sdi sampled on rising sck, framed by cs_n.
  logic [15:0] shreg = 0;
  logic [15:0] words[$];
  always @(posedge sck) shreg = {shreg[14:0], sdi};
  always @(posedge cs_n) words.push_back(shreg);

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_ack(input bit want_b, input string name, output int n);
    n = 0;
    while (!(want_b ? ack_b : ack_a) && n < 100) begin @(negedge clk); n++; end
    chk(name, int'(want_b ? ack_b : ack_a), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk(name, int'(busy), 0);
  endtask

  task automatic count_ldac(input int cycles, output int lows, output int falls);
    logic prev;
    lows = 0; falls = 0; prev = ldac_n;
    repeat (cycles) begin
      if (!ldac_n) lows++;
      if (prev && !ldac_n) falls++;
      prev = ldac_n;
      @(negedge clk);
    end
  endtask

  logic [15:0] exp_words [4] = '{16'h3ABC, 16'hB123, 16'h3ABC, 16'hB123};

  initial begin
    int n, cnt_busy, cnt_cs, lows, falls, k;
    rst_n = 0; tick = 0; req_a = 0; req_b = 0; data_a = 0; data_b = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs()), int'(7'b0000110));
    rst_n = 1;
    @(negedge clk);

    // Single channel A frame.
    words.delete();
    req_a = 1; data_a = 12'hABC;
    wait_ack(0, "grant_a", n);
    chk("grant_latency", n, 1);
    req_a = 0;
    cnt_busy = 1; cnt_cs = 0;
    @(negedge clk);
    chk("ack_a_width", int'(ack_a), 0);
    while (busy && cnt_busy < 200) begin
      if (!cs_n) cnt_cs++;
      cnt_busy++;
      @(negedge clk);
    end
    chk("frame_len", cnt_busy, 67);
    chk("cs_low_len", cnt_cs, 64);
    chk("word_count_a", words.size(), 1);
    if (words.size() > 0) chk("word_a", int'(words[0]), 16'h3ABC);

    // Both channels held: strict alternation starting from A.
    rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);
    words.delete();
    req_a = 1; req_b = 1; data_a = 12'hABC; data_b = 12'h123;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(ack_a || ack_b) && n < 100) begin @(negedge clk); n++; end
      chk("rr_order", int'(ack_b), i % 2);
      if (i == 3) begin req_a = 0; req_b = 0; end
      @(negedge clk);
      chk("rr_ack_width", int'(ack_a | ack_b), 0);
    end
    wait_idle("rr_idle");
    chk("rr_word_count", words.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < words.size()) chk("rr_word", int'(words[i]), int'(exp_words[i]));

    // Tick during SHIFT: latch follows one idle cycle after the frame.
    req_a = 1; data_a = 12'h555;
    wait_ack(0, "grant_tick_frame", n);
    req_a = 0;
    repeat (10) @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    wait_idle("tick_frame_idle");
    chk("ldac_high_in_idle", int'(ldac_n), 1);
    @(negedge clk);
    chk("ldac_start", int'(ldac_n), 0);
    k = 0;
    while (!ldac_n && k < 20) begin k++; @(negedge clk); end
    chk("ldac_width", k, 4);

    // Tick with nothing written: no pulse, stays idle.
    tick = 1; @(negedge clk); tick = 0;
    count_ldac(12, lows, falls);
    chk("skip_no_ldac", lows, 0);
    chk("skip_not_busy", int'(busy), 0);
    // Pending tick must be gone: a following frame alone produces no latch.
    req_b = 1; data_b = 12'h321;
    wait_ack(1, "grant_after_skip", n);
    req_b = 0;
    wait_idle("after_skip_idle");
    count_ldac(10, lows, falls);
    chk("pend_cleared_no_ldac", lows, 0);

    // Two ticks inside one frame merge into one latch.
    req_a = 1; data_a = 12'h0AA;
    wait_ack(0, "grant_two_ticks", n);
    req_a = 0;
    repeat (5) @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    repeat (25) @(negedge clk);
    tick = 1; @(negedge clk); tick = 0;
    wait_idle("two_ticks_idle");
    count_ldac(20, lows, falls);
    chk("two_ticks_pulses", falls, 1);
    chk("two_ticks_width", lows, 4);

    // Tick and request in the same idle cycle, A written beforehand.
    req_a = 1; data_a = 12'h777;
    wait_ack(0, "grant_prelatch", n);
    req_a = 0;
    wait_idle("prelatch_idle");
    tick = 1; req_b = 1; data_b = 12'h0F0;
    @(negedge clk);
    tick = 0;
    chk("latch_first", int'(ldac_n), 0);
    k = 0;
    while (!ack_b && k < 20) begin k++; @(negedge clk); end
    chk("ack_b_after_latch", k, 5);
    req_b = 0;
    wait_idle("tick_req_idle");

    // Reset mid-SHIFT with a simultaneous tick: frame aborts, tick lost.
    req_a = 1; data_a = 12'h9C3;
    wait_ack(0, "grant_abort", n);
    req_a = 0;
    repeat (8) @(negedge clk);
    chk("abort_in_shift", int'(cs_n), 0);
    rst_n = 0; tick = 1;
    @(negedge clk);
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_sck", int'(sck), 0);
    chk("abort_busy", int'(busy), 0);
    tick = 0; rst_n = 1;
    count_ldac(10, lows, falls);
    chk("reset_beats_tick", lows, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
